// File: rtl/shift_seq_unit_pkg.sv
// Shared constants for the sequential shift unit: FSM state encoding and
// shift-direction codes.
package shift_seq_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_seq_unit_if.sv
// Request/response bundle of the sequential shift unit.
//
// Handshake: the master raises start with the operand fields valid; the
// unit accepts it on a rising edge only while busy=0 (IDLE or DONE) and
// latches every field at that edge. busy stays high while shifting, and
// done pulses for exactly one cycle when result/last_out/ovf are valid.
// A start seen while busy=1 is dropped, not queued.
interface shift_seq_unit_if #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 3
);
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic [AMT_W-1:0] amount;
    logic             select;
    logic             ar_select;
    logic             fill_in;
    logic [WIDTH-1:0] result;
    logic             last_out;
    logic             ovf;
    logic             busy;
    logic             done;

    modport master (
        output start, data_in, amount, select, ar_select, fill_in,
        input  result, last_out, ovf, busy, done
    );

    modport slave (
        input  start, data_in, amount, select, ar_select, fill_in,
        output result, last_out, ovf, busy, done
    );
endinterface

// File: rtl/shift_seq_unit_shift_step.sv
// Combinational single-position shifter: one step left or right, logical
// (fill bit enters) or arithmetic (sign held), with the border bits exposed.
module shift_step
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_select,
    input  logic             i_ar_select,
    input  logic             i_fill,
    output logic [WIDTH-1:0] o_s,
    output logic             o_bb_left,
    output logic             o_bb_right,
    output logic             o_sign_loss
);
    logic [WIDTH-1:0] w_right;
    logic [WIDTH-1:0] w_left_log;
    logic [WIDTH-1:0] w_left_ar;

    assign w_right    = {(i_ar_select ? i_d[WIDTH-1] : i_fill), i_d[WIDTH-1:1]};
    assign w_left_log = {i_d[WIDTH-2:0], i_fill};

    // Arithmetic left keeps the sign bit; at WIDTH=2 no middle bits survive.
    generate
        if (WIDTH == 2) begin : g_narrow
            assign w_left_ar = {i_d[1], i_fill};
        end else begin : g_wide
            assign w_left_ar = {i_d[WIDTH-1], i_d[WIDTH-3:0], i_fill};
        end
    endgenerate

    // Select the shifted value for the requested direction and mode.
    always_comb begin
        o_s = w_right;
        if (i_select == DIR_LEFT) begin
            o_s = i_ar_select ? w_left_ar : w_left_log;
        end
    end

    assign o_bb_left   = i_d[WIDTH-1];
    assign o_bb_right  = i_d[0];
    // The bit dropped below the sign disagreed with it: value not representable.
    assign o_sign_loss = (i_select == DIR_LEFT) && i_ar_select
                         && (i_d[WIDTH-2] != i_d[WIDTH-1]);
endmodule

// File: rtl/shift_seq_unit.sv
// Sequential multi-position shifter: one single-position step per clock
// through shift_step, with a start/busy/done handshake and border-bit status.
module shift_seq_unit
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    shift_seq_unit_if.slave  bus,
    output logic [1:0]       o_state
);
    logic [1:0]       r_state;
    logic [AMT_W-1:0] r_count;
    logic [WIDTH-1:0] r_result;
    logic             r_last;
    logic             r_ovf;
    logic             r_sel;
    logic             r_ar;
    logic             r_fill;

    logic [WIDTH-1:0] w_s;
    logic             w_bb_left;
    logic             w_bb_right;
    logic             w_sign_loss;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .i_d         (r_result),
        .i_select    (r_sel),
        .i_ar_select (r_ar),
        .i_fill      (r_fill),
        .o_s         (w_s),
        .o_bb_left   (w_bb_left),
        .o_bb_right  (w_bb_right),
        .o_sign_loss (w_sign_loss)
    );

    // Control FSM plus datapath registers; DONE accepts a new start directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_result <= '0;
            r_last   <= 1'b0;
            r_ovf    <= 1'b0;
            r_sel    <= 1'b0;
            r_ar     <= 1'b0;
            r_fill   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        r_result <= bus.data_in;
                        r_count  <= bus.amount;
                        r_sel    <= bus.select;
                        r_ar     <= bus.ar_select;
                        r_fill   <= bus.fill_in;
                        r_last   <= 1'b0;
                        r_ovf    <= 1'b0;
                        r_state  <= (bus.amount == '0) ? ST_DONE : ST_SHIFT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    r_result <= w_s;
                    r_last   <= (r_sel == DIR_RIGHT) ? w_bb_right : w_bb_left;
                    if (w_sign_loss) begin
                        r_ovf <= 1'b1;
                    end
                    r_count <= r_count - AMT_W'(1);
                    if (r_count == AMT_W'(1)) begin
                        r_state <= ST_DONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.result   = r_result;
    assign bus.last_out = r_last;
    assign bus.ovf      = r_ovf;
    assign bus.busy     = (r_state == ST_SHIFT);
    assign bus.done     = (r_state == ST_DONE);
    assign o_state      = r_state;
endmodule
